// File: rtl/ctrl_pkg.sv
// Shared opcodes, state encodings, error codes and the strobe bundle for the
// hard-wired datapath control sequencer.
package ctrl_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_HALT    = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL = 2'd2;
  localparam logic [1:0] ERR_MEM     = 2'd3;

  // Field order is the packed order of the top-level strobe outputs (MSB first).
  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic zlow_out;
    logic pc_in;
    logic c_out;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
  } strobes_t;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI,
      OP_NOP, OP_HALT: is_legal = 1'b1;
      default:         is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode: current state plus opcode -> datapath strobes,
// ALU op and an opcode-legal flag.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [2:0]      state,
  input  logic [OP_W-1:0] opcode,
  input  logic            first_wait,
  output logic [16:0]     strobes,
  output logic [OP_W-1:0] alu_op,
  output logic            legal
);

  strobes_t s;

  assign strobes = s;

  always_comb begin
    s      = '0;
    alu_op = '0;
    legal  = is_legal(opcode);
    case (state_t'(state))
      S_T0: begin
        s.pc_out = 1'b1;
        s.mar_in = 1'b1;
        s.inc_pc = 1'b1;
        s.z_in   = 1'b1;
        alu_op   = OP_ADD;
      end
      S_T1: begin
        // PC write-back happens once, not on every stalled memory cycle.
        s.zlow_out = 1'b1;
        s.pc_in    = first_wait;
        s.read     = 1'b1;
        s.mdr_in   = 1'b1;
      end
      S_T2: begin
        s.mdr_out = 1'b1;
        s.ir_in   = 1'b1;
      end
      S_T3: begin
        if (legal && opcode != OP_NOP && opcode != OP_HALT) begin
          s.grb   = 1'b1;
          s.r_out = 1'b1;
          s.y_in  = 1'b1;
        end
      end
      S_T4: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            s.grc  = 1'b1;
            s.r_out = 1'b1;
            s.z_in = 1'b1;
            alu_op = opcode;
          end
          OP_ADDI: begin s.c_out = 1'b1; s.z_in = 1'b1; alu_op = OP_ADD; end
          OP_ANDI: begin s.c_out = 1'b1; s.z_in = 1'b1; alu_op = OP_AND; end
          OP_ORI:  begin s.c_out = 1'b1; s.z_in = 1'b1; alu_op = OP_OR;  end
          default: ;
        endcase
      end
      S_T5: begin
        s.zlow_out = 1'b1;
        s.gra      = 1'b1;
        s.r_in     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_ctrl_seq.sv
// Hard-wired fetch/execute control sequencer driving the Datapath strobes.
// Optional retired-instruction counter enabled by CTRL_INSTR_COUNT_EN.
module datapath_ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int OPW         = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           Clear,
  input  logic           run,
  input  logic [31:0]    ir,
  input  logic           mem_ready,
  output logic           PCout,
  output logic           MARin,
  output logic           IncPC,
  output logic           Zin,
  output logic           Read,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Yin,
  output logic           Zlowout,
  output logic           PCin,
  output logic           Cout,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic [OPW-1:0] alu_op,
  output logic           halted,
  output logic [1:0]     err_code,
  output logic [2:0]     state_dbg
`ifdef CTRL_INSTR_COUNT_EN
  ,
  output logic [31:0]    instr_count
`endif
);

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t          state_q;
  logic [7:0]      wait_q;
  logic [1:0]      err_q;
  logic [OP_W-1:0] op_q;
  logic [OP_W-1:0] ir_op;
  logic [OP_W-1:0] dec_op;
  logic [16:0]     dec_strobes;
  logic [OP_W-1:0] dec_alu;
  logic            dec_legal;
  logic            unused_ir_fields;

  assign ir_op            = ir[31:27];
  assign unused_ir_fields = ^ir[26:0];
  // IR is only trustworthy in T3; afterwards the latched copy steers T4/T5.
  assign dec_op = (state_q == S_T3) ? ir_op : op_q;

  ctrl_decode u_decode (
    .state      (state_q),
    .opcode     (dec_op),
    .first_wait (wait_q == 8'd0),
    .strobes    (dec_strobes),
    .alu_op     (dec_alu),
    .legal      (dec_legal)
  );

  assign {PCout, MARin, IncPC, Zin, Read, MDRin, MDRout, IRin,
          Yin, Zlowout, PCin, Cout, Gra, Grb, Grc, Rin, Rout} = dec_strobes;
  assign alu_op    = OPW'(dec_alu);
  assign halted    = (state_q == S_HALT);
  assign err_code  = err_q;
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (state_q == S_T3) op_q <= ir_op;
  end

  always_ff @(posedge clk or negedge Clear) begin
    if (!Clear) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      err_q   <= ERR_NONE;
    end else begin
      case (state_q)
        S_IDLE: if (run) state_q <= S_T0;
        S_T0: begin
          state_q <= S_T1;
          wait_q  <= '0;
        end
        S_T1: begin
          // A ready on the timeout cycle still completes the fetch.
          if (mem_ready) begin
            state_q <= S_T2;
            wait_q  <= '0;
          end else if (wait_q + 8'd1 == TMO) begin
            state_q <= S_HALT;
            err_q   <= ERR_MEM;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_T2: state_q <= S_T3;
        S_T3: begin
          if (ir_op == OP_NOP) begin
            state_q <= run ? S_T0 : S_IDLE;
          end else if (ir_op == OP_HALT) begin
            state_q <= S_HALT;
            err_q   <= ERR_HALT;
          end else if (!dec_legal) begin
            state_q <= S_HALT;
            err_q   <= ERR_ILLEGAL;
          end else begin
            state_q <= S_T4;
          end
        end
        S_T4: state_q <= S_T5;
        S_T5: state_q <= run ? S_T0 : S_IDLE;
        default: ;
      endcase
    end
  end

`ifdef CTRL_INSTR_COUNT_EN
  logic [31:0] instr_cnt_q;
  logic        retire;

  assign retire      = (state_q == S_T5) || (state_q == S_T3 && ir_op == OP_NOP);
  assign instr_count = instr_cnt_q;

  always_ff @(posedge clk or negedge Clear) begin
    if (!Clear)      instr_cnt_q <= '0;
    else if (retire) instr_cnt_q <= instr_cnt_q + 32'd1;
  end
`endif

endmodule
